// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

   // Arbiter control states.
   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   // Width of a requester index. A single requester still needs one bit.
   function automatic int id_width(input int nreq);
      return (nreq > 1) ? $clog2(nreq) : 1;
   endfunction

   // Width of the beat counter. It must be able to hold BURST-1.
   function automatic int cnt_width(input int burst);
      return (burst > 1) ? $clog2(burst + 1) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Returns the first set request at or after start_i, wrapping at NREQ.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int ID_W = id_width(NREQ)
)(
   input  logic [NREQ-1:0] req_i,
   input  logic [ID_W-1:0] start_i,
   output logic            found_o,
   output logic [ID_W-1:0] idx_o
);

   // Index that lies k positions after base, wrapped into 0..NREQ-1.
   function automatic logic [ID_W-1:0] add_mod(input logic [ID_W-1:0] base, input int k);
      int sum;
      sum = int'(base) + k;
      if (sum >= NREQ) begin
         sum = sum - NREQ;
      end
      return ID_W'(sum);
   endfunction

   // Scan from the far end back toward start_i so the nearest request wins.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_i[add_mod(start_i, k)]) begin
            found_o = 1'b1;
            idx_o   = add_mod(start_i, k);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the single write port of a FIFO.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no grant; pick the next requester after last (bubble cycle)
//   GRANT | owner drives the FIFO write port for up to BURST beats
//
// The grant ends after BURST writes, or as soon as the owner drops valid.
// A full FIFO stalls the burst without revoking the grant.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter  int NREQ  = 4,
   parameter  int WIDTH = 3,
   parameter  int BURST = 4,
   localparam int ID_W  = id_width(NREQ),
   localparam int CNT_W = cnt_width(BURST)
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   input  logic                  fifo_full,
   output logic                  fifo_we,
   output logic [WIDTH-1:0]      fifo_wdata,
   output logic [ID_W-1:0]       owner,
   output logic                  busy
);

   localparam logic [ID_W-1:0]  LAST_ID    = ID_W'(NREQ - 1);
   localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST - 1);

   arb_state_e       state_q, state_d;
   logic [ID_W-1:0]  owner_q, owner_d;
   logic [ID_W-1:0]  last_q,  last_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;

   logic [ID_W-1:0]  start_idx;
   logic             pick_found;
   logic [ID_W-1:0]  pick_idx;
   logic             owner_valid;
   logic             beat_wr;
   logic [WIDTH-1:0] data_arr [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign data_arr[i] = req_data[i*WIDTH +: WIDTH];
   end

   // The search begins one past the previous owner so it goes last next time.
   assign start_idx = (last_q == LAST_ID) ? '0 : last_q + 1'b1;

   rr_pick #(
      .NREQ (NREQ)
   ) u_pick (
      .req_i   (req_valid),
      .start_i (start_idx),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   assign owner_valid = req_valid[owner_q];
   assign beat_wr     = (state_q == GRANT) && owner_valid && !fifo_full;

   assign owner = owner_q;
   assign busy  = (state_q == GRANT);

   // Write-port mux and handshake; all quiet outside GRANT.
   always_comb begin
      req_ready  = '0;
      fifo_we    = 1'b0;
      fifo_wdata = '0;
      if (state_q == GRANT) begin
         req_ready[owner_q] = !fifo_full;
         fifo_we            = owner_valid && !fifo_full;
         fifo_wdata         = data_arr[owner_q];
      end
   end

   // Next-state decision for the grant, owner, fairness pointer and beat count.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               owner_d = pick_idx;
               cnt_d   = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (!owner_valid) begin
               state_d = IDLE;
               last_d  = owner_q;
               cnt_d   = '0;
            end else if (beat_wr) begin
               if (cnt_q == BURST_LAST) begin
                  state_d = IDLE;
                  last_d  = owner_q;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Arbiter registers with synchronous reset; reset drops any grant in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= '0;
         last_q  <= LAST_ID;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus a
// randomized run against a behavioural model of the grant rules.
module tb_fifo_wr_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 3;
   localparam int BURST = 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic                  fifo_full;
   logic                  fifo_we;
   logic [WIDTH-1:0]      fifo_wdata;
   logic [1:0]            owner;
   logic                  busy;

   int n_pass;
   int n_total;

   fifo_wr_arbiter #(
      .NREQ  (NREQ),
      .WIDTH (WIDTH),
      .BURST (BURST)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .fifo_full  (fifo_full),
      .fifo_we    (fifo_we),
      .fifo_wdata (fifo_wdata),
      .owner      (owner),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Behavioural model: who holds the grant and how many beats it has written.
   int m_busy  = 0;
   int m_owner = 0;
   int m_last  = NREQ - 1;
   int m_beats = 0;
   int m_pick;

   function automatic int next_owner(input logic [NREQ-1:0] v, input int last);
      for (int k = 1; k <= NREQ; k++) begin
         if (v[(last + k) % NREQ]) return (last + k) % NREQ;
      end
      return -1;
   endfunction

   always @(posedge clk) begin
      if (rst === 1'b1) begin
         m_busy  = 0;
         m_owner = 0;
         m_last  = NREQ - 1;
         m_beats = 0;
      end else if (m_busy == 0) begin
         m_pick = next_owner(req_valid, m_last);
         if (m_pick >= 0) begin
            m_busy  = 1;
            m_owner = m_pick;
            m_beats = 0;
         end
      end else if (!req_valid[m_owner]) begin
         m_busy = 0;
         m_last = m_owner;
      end else if (!fifo_full) begin
         m_beats = m_beats + 1;
         if (m_beats == BURST) begin
            m_busy = 0;
            m_last = m_owner;
         end
      end
   end

   // Leaves the bench at a falling edge right after one reset clock.
   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      req_valid = '0;
      fifo_full = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int c = 0; c < 10; c++) begin
         req_valid = '0;
         fifo_full = 1'b0;
         req_data  = 12'($urandom);
         #1;
         n_total++;
         if (busy !== 1'b0) $display("FAIL reset_busy c=%0d got %b want 0", c, busy);
         else n_pass++;
         n_total++;
         if (fifo_we !== 1'b0) $display("FAIL reset_we c=%0d got %b want 0", c, fifo_we);
         else n_pass++;
         n_total++;
         if (req_ready !== 4'b0000) $display("FAIL reset_ready c=%0d got %b want 0000", c, req_ready);
         else n_pass++;
         n_total++;
         if (fifo_wdata !== 3'd0) $display("FAIL reset_wdata c=%0d got %0d want 0", c, fifo_wdata);
         else n_pass++;
         n_total++;
         if (owner !== 2'd0) $display("FAIL reset_owner c=%0d got %0d want 0", c, owner);
         else n_pass++;
         @(negedge clk);
      end
   endtask

   task automatic test_alternating();
      int exp_own;
      bit exp_busy;
      do_reset();
      for (int c = 0; c < 15; c++) begin
         req_valid = 4'b0101;
         fifo_full = 1'b0;
         req_data  = 12'($urandom);
         #1;
         exp_busy = (c % 5) != 0;
         exp_own  = ((c / 5) % 2 == 0) ? 0 : 2;
         n_total++;
         if (busy !== exp_busy) $display("FAIL alt_busy c=%0d got %b want %b", c, busy, exp_busy);
         else n_pass++;
         n_total++;
         if (fifo_we !== exp_busy) $display("FAIL alt_we c=%0d got %b want %b", c, fifo_we, exp_busy);
         else n_pass++;
         if (exp_busy) begin
            n_total++;
            if (owner !== 2'(exp_own)) $display("FAIL alt_owner c=%0d got %0d want %0d", c, owner, exp_own);
            else n_pass++;
            n_total++;
            if (fifo_wdata !== req_data[exp_own*WIDTH +: WIDTH])
               $display("FAIL alt_wdata c=%0d got %0d want %0d", c, fifo_wdata, req_data[exp_own*WIDTH +: WIDTH]);
            else n_pass++;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_single_drop();
      int nw;
      nw = 0;
      do_reset();
      for (int c = 0; c < 6; c++) begin
         req_valid = (c < 3) ? 4'b0010 : ((c == 3) ? 4'b0000 : 4'b1111);
         fifo_full = 1'b0;
         req_data  = 12'($urandom);
         #1;
         if (fifo_we === 1'b1 && c < 4) begin
            nw++;
            n_total++;
            if (fifo_wdata !== req_data[5:3] || owner !== 2'd1)
               $display("FAIL drop_wdata c=%0d got %0d/own%0d want %0d/own1", c, fifo_wdata, owner, req_data[5:3]);
            else n_pass++;
         end
         if (c == 3) begin
            n_total++;
            if (busy !== 1'b1 || fifo_we !== 1'b0)
               $display("FAIL drop_cycle busy/we got %b/%b want 1/0", busy, fifo_we);
            else n_pass++;
         end
         if (c == 4) begin
            n_total++;
            if (busy !== 1'b0) $display("FAIL drop_idle got busy=%b want 0", busy);
            else n_pass++;
         end
         if (c == 5) begin
            n_total++;
            if (busy !== 1'b1 || owner !== 2'd2)
               $display("FAIL drop_next_owner got busy=%b owner=%0d want busy=1 owner=2", busy, owner);
            else n_pass++;
         end
         @(negedge clk);
      end
      n_total++;
      if (nw != 2) $display("FAIL drop_write_count got %0d want 2", nw);
      else n_pass++;
   endtask

   task automatic test_full_stall();
      int nw;
      nw = 0;
      do_reset();
      for (int c = 0; c < 11; c++) begin
         req_valid = 4'b1000;
         fifo_full = (c >= 3 && c <= 7);
         req_data  = 12'($urandom);
         #1;
         if (c == 1 || c == 2) begin
            n_total++;
            if (fifo_we !== 1'b1 || owner !== 2'd3)
               $display("FAIL stall_pre c=%0d got we=%b owner=%0d want we=1 owner=3", c, fifo_we, owner);
            else n_pass++;
         end
         if (c >= 3 && c <= 7) begin
            n_total++;
            if (fifo_we !== 1'b0 || req_ready !== 4'b0000)
               $display("FAIL stall_quiet c=%0d got we=%b ready=%b want 0/0000", c, fifo_we, req_ready);
            else n_pass++;
            n_total++;
            if (busy !== 1'b1 || owner !== 2'd3)
               $display("FAIL stall_hold c=%0d got busy=%b owner=%0d want 1/3", c, busy, owner);
            else n_pass++;
         end
         if (c >= 8 && fifo_we === 1'b1) begin
            nw++;
            n_total++;
            if (fifo_wdata !== req_data[11:9])
               $display("FAIL stall_wdata c=%0d got %0d want %0d", c, fifo_wdata, req_data[11:9]);
            else n_pass++;
         end
         if (c == 10) begin
            n_total++;
            if (busy !== 1'b0) $display("FAIL stall_end got busy=%b want 0", busy);
            else n_pass++;
         end
         @(negedge clk);
      end
      n_total++;
      if (nw != 2) $display("FAIL stall_post_writes got %0d want 2", nw);
      else n_pass++;
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      for (int c = 0; c < 8; c++) begin
         rst       = (c == 5);
         req_valid = (c < 2) ? 4'b0010 : (c == 2) ? 4'b0000 : (c < 6) ? 4'b0100 : 4'b1111;
         fifo_full = 1'b0;
         req_data  = 12'($urandom);
         #1;
         if (c == 4 || c == 5) begin
            n_total++;
            if (busy !== 1'b1 || owner !== 2'd2)
               $display("FAIL rstmid_grant c=%0d got busy=%b owner=%0d want 1/2", c, busy, owner);
            else n_pass++;
         end
         if (c == 6) begin
            n_total++;
            if (busy !== 1'b0 || fifo_we !== 1'b0 || owner !== 2'd0 || req_ready !== 4'b0000)
               $display("FAIL rstmid_after got busy=%b we=%b owner=%0d ready=%b want 0/0/0/0000",
                        busy, fifo_we, owner, req_ready);
            else n_pass++;
         end
         if (c == 7) begin
            n_total++;
            if (busy !== 1'b1 || owner !== 2'd0)
               $display("FAIL rstmid_first_grant got busy=%b owner=%0d want 1/0", busy, owner);
            else n_pass++;
         end
         @(negedge clk);
      end
      rst = 1'b0;
   endtask

   task automatic test_back_to_back();
      int nw;
      int exp_own;
      bit exp_busy;
      nw = 0;
      do_reset();
      for (int c = 0; c < 40; c++) begin
         req_valid = 4'b1111;
         fifo_full = 1'b0;
         req_data  = 12'($urandom);
         #1;
         exp_busy = (c % 5) != 0;
         exp_own  = (c / 5) % NREQ;
         if (fifo_we === 1'b1) nw++;
         n_total++;
         if (busy !== exp_busy) $display("FAIL b2b_busy c=%0d got %b want %b", c, busy, exp_busy);
         else n_pass++;
         if (exp_busy) begin
            n_total++;
            if (owner !== 2'(exp_own) || req_ready !== 4'(1 << exp_own))
               $display("FAIL b2b_owner c=%0d got owner=%0d ready=%b want owner=%0d", c, owner, req_ready, exp_own);
            else n_pass++;
            n_total++;
            if (fifo_we !== 1'b1 || fifo_wdata !== req_data[exp_own*WIDTH +: WIDTH])
               $display("FAIL b2b_write c=%0d got we=%b data=%0d want we=1 data=%0d",
                        c, fifo_we, fifo_wdata, req_data[exp_own*WIDTH +: WIDTH]);
            else n_pass++;
         end
         @(negedge clk);
      end
      n_total++;
      if (nw != 32) $display("FAIL b2b_total_writes got %0d want 32", nw);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [NREQ-1:0]  exp_ready;
      logic             exp_we;
      logic [WIDTH-1:0] exp_data;
      do_reset();
      req_valid = 4'($urandom);
      for (int c = 0; c < 600; c++) begin
         rst = ($urandom_range(0, 99) < 2);
         if ($urandom_range(0, 9) < 3) req_valid = 4'($urandom);
         fifo_full = ($urandom_range(0, 3) == 0);
         req_data  = 12'($urandom);
         #1;
         exp_ready = '0;
         exp_we    = 1'b0;
         exp_data  = '0;
         if (m_busy != 0) begin
            exp_ready[m_owner] = !fifo_full;
            exp_we             = req_valid[m_owner] && !fifo_full;
            exp_data           = req_data[m_owner*WIDTH +: WIDTH];
         end
         n_total++;
         if (busy !== (m_busy != 0)) $display("FAIL rnd_busy c=%0d got %b want %0d", c, busy, m_busy);
         else n_pass++;
         n_total++;
         if (fifo_we !== exp_we || req_ready !== exp_ready)
            $display("FAIL rnd_handshake c=%0d got we=%b ready=%b want we=%b ready=%b",
                     c, fifo_we, req_ready, exp_we, exp_ready);
         else n_pass++;
         n_total++;
         if (fifo_wdata !== exp_data) $display("FAIL rnd_wdata c=%0d got %0d want %0d", c, fifo_wdata, exp_data);
         else n_pass++;
         if (m_busy != 0) begin
            n_total++;
            if (owner !== 2'(m_owner)) $display("FAIL rnd_owner c=%0d got %0d want %0d", c, owner, m_owner);
            else n_pass++;
         end
         @(negedge clk);
      end
      rst = 1'b0;
   endtask

   initial begin
      n_pass    = 0;
      n_total   = 0;
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      fifo_full = 1'b0;
      test_reset();
      test_alternating();
      test_single_drop();
      test_full_stall();
      test_reset_mid_burst();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
